// File: rtl/hcf_pkg.sv
// Shared types and width helpers for the sequential binary-GCD engine.
package hcf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must hold up to 2*WIDTH-1 RUN cycles.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width);
  endfunction

  // Common power-of-two shift never exceeds WIDTH-1 for non-zero operands.
  function automatic int k_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/hcf_step.sv
// One combinational Stein step: reduces (a, b) and tracks the shared power of two k.
module hcf_step
  import hcf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = k_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic [KW-1:0]    k_next,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    a_next = a;
    b_next = b;
    k_next = k;
    done   = 1'b0;
    // The restored factor fits in WIDTH bits because it never exceeds the smaller operand.
    result = a << k;
    if (a == b) begin
      done = 1'b1;
    end else if (!a[0] && !b[0]) begin
      a_next = a >> 1;
      b_next = b >> 1;
      k_next = k + 1'b1;
    end else if (!a[0]) begin
      a_next = a >> 1;
    end else if (!b[0]) begin
      b_next = b >> 1;
    end else if (a > b) begin
      a_next = (a - b) >> 1;
    end else begin
      b_next = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/hcf_engine.sv
// Sequential HCF engine: valid/ready in, one Stein step per clock, valid/ready out.
module hcf_engine
  import hcf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hcf_out,
  output logic             zero_flag,
  output logic [CW-1:0]    cycles
);

  localparam int KW = k_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_next, b_next, step_result;
  logic [KW-1:0]    k_next;
  logic             step_done;

  hcf_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .a      (a),
    .b      (b),
    .k      (k),
    .a_next (a_next),
    .b_next (b_next),
    .k_next (k_next),
    .done   (step_done),
    .result (step_result)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      k         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      hcf_out   <= '0;
      zero_flag <= 1'b0;
      cycles    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a         <= in1;
            b         <= in2;
            k         <= '0;
            cnt       <= '0;
            cycles    <= '0;
            zero_flag <= 1'b0;
            // With a zero operand the answer is simply the other one (or 0 when both are 0).
            if (in1 == '0 || in2 == '0) begin
              hcf_out   <= in1 | in2;
              zero_flag <= (in1 == '0) && (in2 == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          a   <= a_next;
          b   <= b_next;
          k   <= k_next;
          cnt <= cnt + 1'b1;
          if (step_done) begin
            hcf_out   <= step_result;
            cycles    <= cnt + 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hcf_engine.sv
// Bench for hcf_engine at WIDTH=8 and WIDTH=16 against an Euclid reference model.
module tb_hcf_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8, z8;
  logic [7:0]  a8 = '0, b8 = '0, h8;
  logic [3:0]  c8;
  logic        iv16 = 1'b0, or16 = 1'b0, ir16, ov16, z16;
  logic [15:0] a16 = '0, b16 = '0, h16;
  logic [4:0]  c16;

  hcf_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
    .out_valid(ov8), .out_ready(or8), .hcf_out(h8), .zero_flag(z8), .cycles(c8)
  );

  hcf_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in1(a16), .in2(b16),
    .out_valid(ov16), .out_ready(or16), .hcf_out(h16), .zero_flag(z16), .cycles(c16)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] r_h;
  logic        r_z;
  int          r_c, r_lat;
  logic        r_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Offers one pair, counts edges after acceptance until out_valid, captures and consumes the result.
  task automatic xfer(input int w, input logic [15:0] x, input logic [15:0] y);
    r_lat = 0;
    if (w == 8) begin iv8 = 1'b1; a8 = x[7:0]; b8 = y[7:0]; end
    else begin iv16 = 1'b1; a16 = x; b16 = y; end
    @(posedge clk); #1;
    iv8 = 1'b0; iv16 = 1'b0;
    r_valid = (w == 8) ? ov8 : ov16;
    while (!r_valid && r_lat < 64) begin
      @(posedge clk); #1;
      r_lat++;
      r_valid = (w == 8) ? ov8 : ov16;
    end
    chk("out_valid_timeout", {31'd0, r_valid}, 32'd1);
    r_h = (w == 8) ? {8'd0, h8} : h16;
    r_z = (w == 8) ? z8 : z16;
    r_c = (w == 8) ? int'(c8) : int'(c16);
    if (w == 8) or8 = 1'b1; else or16 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0; or16 = 1'b0;
  endtask

  int dx[9] = '{10, 12, 7, 18, 8, 255, 0, 9, 0};
  int dy[9] = '{5, 4, 5, 24, 8, 255, 9, 0, 0};
  int dc[9] = '{2, 4, 4, 5, 1, 1, 0, 0, 0};

  initial begin
    int x, y, f, w, lim;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, ir8}, 32'd1);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_hcf_out", {24'd0, h8}, 32'd0);
    chk("rst_zero_flag", {31'd0, z8}, 32'd0);
    chk("rst_cycles", {28'd0, c8}, 32'd0);
    chk("rst_out_valid16", {31'd0, ov16}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      xfer(8, 16'(dx[i]), 16'(dy[i]));
      chk("dir_hcf", {16'd0, r_h}, 32'(ref_gcd(dx[i], dy[i])));
      chk("dir_cycles", 32'(r_c), 32'(dc[i]));
      chk("dir_latency", 32'(r_lat), 32'(dc[i]));
      chk("dir_zero_flag", {31'd0, r_z}, {31'd0, dx[i] == 0 && dy[i] == 0});
    end

    // Backpressure: result held, in_ready low, new operands ignored.
    iv8 = 1'b1; a8 = 8'd18; b8 = 8'd24;
    @(posedge clk); #1;
    a8 = 8'd99; b8 = 8'd33;
    for (int i = 0; i < 20 && !ov8; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {18'd0, ov8, ir8, z8, c8, h8}, {18'd0, 1'b1, 1'b0, 1'b0, 4'd5, 8'd6});
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("bp_release_valid", {31'd0, ov8}, 32'd0);
    chk("bp_release_ready", {31'd0, ir8}, 32'd1);
    xfer(8, 16'd99, 16'd33);
    chk("bp_next_hcf", {16'd0, r_h}, 32'd33);

    // Reset while running discards the result in flight.
    iv8 = 1'b1; a8 = 8'd128; b8 = 8'd1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, ir8}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, ir8}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(8, 16'd6, 16'd9);
    chk("post_rst_hcf", {16'd0, r_h}, 32'd3);
    chk("post_rst_cycles", 32'(r_c), 32'd3);

    for (int n = 0; n < 1200; n++) begin
      w = (n < 600) ? 8 : 16;
      lim = (w == 8) ? 255 : 65535;
      case ($urandom_range(0, 3))
        0: begin x = int'($urandom_range(0, lim)); y = int'($urandom_range(0, lim)); end
        1: begin
          f = int'($urandom_range(1, 40));
          x = (f * int'($urandom_range(0, 60))) & lim;
          y = (f * int'($urandom_range(0, 60))) & lim;
        end
        2: begin
          f = int'($urandom_range(0, w - 2));
          x = (int'($urandom_range(1, lim)) << f) & lim;
          y = (int'($urandom_range(1, lim)) << f) & lim;
        end
        default: begin x = int'($urandom_range(0, 3)); y = int'($urandom_range(0, lim)); end
      endcase
      xfer(w, 16'(x), 16'(y));
      chk("rnd_hcf", {16'd0, r_h}, 32'(ref_gcd(x, y)));
      chk("rnd_zero_flag", {31'd0, r_z}, {31'd0, x == 0 && y == 0});
      chk("rnd_latency", 32'(r_lat), 32'(r_c));
      if (x == 0 || y == 0)
        chk("rnd_zero_cycles", 32'(r_c), 32'd0);
      else
        chk("rnd_cycle_range", {31'd0, r_c >= 1 && r_c <= 2 * w - 1}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
